// File: rtl/mul_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier keeping the low product word.
// One add_16 is shared across 16 data-independent iterations.

module add_16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);
  // Ripple chain stops at bit 14's carry; the bit-15 carry is never formed.
  logic [15:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
    if (i < 15) begin : g_cy
      assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end
endmodule

module mul_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        busy,
  output logic        done
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_mcand, r_mplier, r_acc, r_out;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic [15:0] w_sum, w_acc_nxt;
  logic        w_last;

  add_16 u_add (
    .i_a   (r_acc),
    .i_b   (r_mcand),
    .o_sum (w_sum)
  );

  assign w_acc_nxt = r_mplier[0] ? w_sum : r_acc;
  assign w_last    = (r_cnt == 4'd15);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[15:1]};
          r_cnt    <= r_cnt + 4'd1;
          if (w_last) begin
            r_out  <= w_acc_nxt;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out  = r_out;
  assign busy = (r_state == S_RUN);
  assign done = r_done;
endmodule

// File: doc/mul_16.md
# mul_16

Sequential 16×16 unsigned shift-and-add multiplier for the ALU datapath, sitting directly downstream of `add_16`. It instantiates one `add_16` as its only adder and feeds that adder with the running partial product and the shifted multiplicand, one iteration per clock. The output is the low 16 bits of the product. Because only the low word is kept, the result is also correct for two's-complement operands.

## Interface

Parameters:
- none. Width is fixed at 16 and the iteration count is fixed at 16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  request a multiply; sampled only when idle.
- `a`  in  16  multiplicand; sampled on the accepting edge only.
- `b`  in  16  multiplier; sampled on the accepting edge only.
- `out`  out  16  low 16 bits of `a*b` from the last completed operation.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  single-cycle pulse when `out` has just been updated.

## Operation

Internal registers:
- `mcand[15:0]`: multiplicand.
- `mplier[15:0]`: multiplier.
- `acc[15:0]`: running partial product.
- `cnt[3:0]`: iteration counter.
- state: one of IDLE, RUN.

Adder connection:
- `add_16` inputs are `acc` and `mcand`.
- Its sum output is used whenever `mplier[0]`=1.
- The carry out of bit 15 is discarded, so all arithmetic is modulo 2^16.

IDLE:
- `busy`=0.
- On an edge with `start`=1: `mcand`←`a`, `mplier`←`b`, `acc`←0, `cnt`←0, go to RUN.
- `start`=0: hold all registers.

RUN, on each edge:
- `acc` ← `mplier[0]` ? `acc+mcand` : `acc`.
- `mcand` ← `mcand`<<1, zero fill.
- `mplier` ← `mplier`>>1, zero fill.
- `cnt` ← `cnt`+1.
- If `cnt`==15 before the edge (the 16th iteration): `out` ← the new `acc` value, `done`←1, go to IDLE.

Iteration count:
- The count is always exactly 16. There is no early exit when `mplier` reaches 0, so latency is data-independent.

Input rules:
- `start` is ignored while in RUN. It is not queued.
- `a` and `b` may change freely after the accepting edge without affecting the operation.
- `out` holds its value between completions and is never updated mid-operation.
- `done` is asserted only for the one cycle following the completing edge.

Reset:
- `rst_n`=0 at any edge, including mid-RUN, has the following effect: state←IDLE, `out`←0, `busy`←0, `done`←0, `acc`/`mcand`/`mplier`/`cnt`←0.
- An aborted operation produces no `done`.

## Timing

- Reset values: `out`=16'h0000, `busy`=0, `done`=0.
- Let E0 be the edge that accepts `start`. Iterations occur on edges E1…E16.
- `busy` is high from after E0 until after E16.
- `out` and `done` update on E16, giving a latency of 16 cycles from E0 to `done` visible.
- `done`=1 only in the cycle between E16 and E17.
- Back-to-back operation: the FSM is in IDLE after E16, so `start`=1 sampled at E17 is accepted. The minimum issue interval is 17 cycles.
- Simultaneous `rst_n`=0 and `start`=1: reset wins and the request is dropped.
- `start`=1 on the same edge as E16 (still in RUN): ignored.

## Test plan

- Basic multiply: reset, then `a`=3, `b`=5, pulse `start`.
  - `busy`=1 for 16 cycles.
  - `done` pulses exactly 16 cycles after the accepting edge.
  - `out`=16'h000F.
- Modulo wrap (low word only):
  - `a`=16'hFFFF, `b`=16'hFFFF → `out`=16'h0001.
  - `a`=16'h0100, `b`=16'h0100 → `out`=16'h0000.
  - `a`=16'h3CC3, `b`=16'h0002 → `out`=16'h7986.
- Ignored start: issue `a`=7, `b`=6. At cycle 5 of RUN, raise `start` with `a`=9, `b`=9 and change `a`/`b`.
  - Exactly one `done`, at cycle 16, with `out`=16'h002A.
  - No second operation starts.
- Back-to-back: hold `start`=1 continuously with `a`=2, `b`=8 and then `a`=0, `b`=16'h1234.
  - `done` pulses 17 cycles apart.
  - `out`=16'h0010, then `out`=16'h0000.
- Reset mid-operation: start `a`=16'h1234, `b`=16'h0003, then drive `rst_n`=0 for 1 cycle at RUN cycle 8.
  - `busy`=0, `out`=0, no `done` for 20 following cycles.
  - A new request `a`=4, `b`=4 then yields `out`=16'h0010.
- Reset values: hold `rst_n`=0 with `start`=1 for 3 cycles → `out`=0, `busy`=0, `done`=0 throughout.
